// File: rtl/nand_share_arb_pkg.sv
// ---------------------------------------------------------------------------
// nand_arb_pkg
// Shared definitions for the NAND-sharing arbiter slice:
//   - state_t      : sequencer states (IDLE, EXEC, DONE)
//   - DEFAULT_N    : default requester count
//   - DEFAULT_WIDTH: default operand/result width
//   - rr_pick      : round-robin winner search, modulo n, for up to 8 requesters
// ---------------------------------------------------------------------------
package nand_arb_pkg;

  localparam int DEFAULT_N     = 4;
  localparam int DEFAULT_WIDTH = 16;
  localparam int MAX_N         = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Search starts one past the previous winner and wraps modulo n, so the
  // previous winner is the last candidate considered. Returns 'last' when no
  // request is pending; callers qualify the result with |req.
  function automatic logic [2:0] rr_pick(input logic [7:0] req,
                                         input logic [2:0] last,
                                         input logic [3:0] n);
    logic [2:0] win;
    logic       found;
    logic [3:0] idx;
    win   = last;
    found = 1'b0;
    for (int k = 1; k <= MAX_N; k++) begin
      // last < n and k <= n, so one conditional subtract is a full modulo.
      idx = {1'b0, last} + 4'(k);
      if (idx >= n) begin
        idx = idx - n;
      end else begin
        idx = idx;
      end
      if ((4'(k) <= n) && !found && req[idx[2:0]]) begin
        win   = idx[2:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/nand_share_arb_if.sv
// ---------------------------------------------------------------------------
// nand_share_arb_if
// Request/response bundle between N requesters and the shared NAND arbiter.
//   req_valid/req_a/req_b : per-requester operand handshake (slice i*WIDTH)
//   req_ready             : per-requester accept, at most one bit high
//   rsp_valid/rsp_id/rsp_data/rsp_ready : common tagged response channel
// Modports: master = requester/consumer side, slave = arbiter side.
// ---------------------------------------------------------------------------
interface nand_share_arb_if
  import nand_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDW   = $clog2(N)
);

  logic [N-1:0]       req_valid;
  logic [N*WIDTH-1:0] req_a;
  logic [N*WIDTH-1:0] req_b;
  logic [N-1:0]       req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/nand_share_arb_nand_word.sv
// ---------------------------------------------------------------------------
// nand_word
// WIDTH-bit bitwise NAND built from single-bit NAND cells; this is the one
// shared evaluation unit behind the arbiter.
//   a, b : operands
//   y    : ~(a & b)
// nand_bit is the single-bit cell it is assembled from.
// ---------------------------------------------------------------------------
module nand_bit (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = ~(a & b);
endmodule

module nand_word #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    nand_bit u_nand_bit (
      .a (a[i]),
      .b (b[i]),
      .y (y[i])
    );
  end

endmodule

// File: rtl/nand_share_arb.sv
// ---------------------------------------------------------------------------
// nand_share_arb
// Round-robin arbiter/sequencer sharing one WIDTH-bit NAND unit among N
// requesters. One operation in flight: accept (IDLE) -> evaluate (EXEC) ->
// present response (DONE) until consumed.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, wins over every state
//   bus : nand_share_arb_if.slave (request handshakes + tagged response)
// req_ready is combinational from state, req_valid and last grant; all
// response outputs come straight from registers.
// ---------------------------------------------------------------------------
module nand_share_arb
  import nand_arb_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int IDW   = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  nand_share_arb_if.slave bus
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

  state_t           state_r;
  logic [IDW-1:0]   last_grant_r;
  logic [IDW-1:0]   id_r;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_valid_r;

  logic [7:0]       req_pad_s;
  logic             any_req_s;
  logic [IDW-1:0]   winner_s;
  logic [N-1:0]     req_ready_s;
  logic [WIDTH-1:0] sel_a_s;
  logic [WIDTH-1:0] sel_b_s;
  logic [WIDTH-1:0] nand_y_s;

  // Round-robin winner and the winner's operand slices.
  always_comb begin
    req_pad_s = 8'(bus.req_valid);
    any_req_s = |bus.req_valid;
    winner_s  = IDW'(rr_pick(req_pad_s, 3'(last_grant_r), 4'(N)));
    sel_a_s   = bus.req_a[winner_s*WIDTH +: WIDTH];
    sel_b_s   = bus.req_b[winner_s*WIDTH +: WIDTH];
  end

  // Accept strobe: only in IDLE, only to the winner, never during reset.
  always_comb begin
    req_ready_s = {N{1'b0}};
    if (!rst && (state_r == IDLE) && any_req_s) begin
      req_ready_s[winner_s] = 1'b1;
    end else begin
      req_ready_s = {N{1'b0}};
    end
  end

  nand_word #(
    .WIDTH (WIDTH)
  ) u_nand_word (
    .a (op_a_r),
    .b (op_b_r),
    .y (nand_y_s)
  );

  // Sequencer: accept, evaluate, hold response until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= LAST_RST;
      id_r         <= {IDW{1'b0}};
      op_a_r       <= {WIDTH{1'b0}};
      op_b_r       <= {WIDTH{1'b0}};
      rsp_data_r   <= {WIDTH{1'b0}};
      rsp_valid_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            op_a_r       <= sel_a_s;
            op_b_r       <= sel_b_s;
            id_r         <= winner_s;
            last_grant_r <= winner_s;
            state_r      <= EXEC;
          end else begin
            state_r      <= IDLE;
          end
        end
        EXEC: begin
          rsp_data_r  <= nand_y_s;
          rsp_valid_r <= 1'b1;
          state_r     <= DONE;
        end
        DONE: begin
          if (bus.rsp_ready) begin
            rsp_valid_r <= 1'b0;
            state_r     <= IDLE;
          end else begin
            state_r     <= DONE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = id_r;
  assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_nand_share_arb.sv
// ---------------------------------------------------------------------------
// tb_nand_share_arb
// Randomised and directed stimulus against a cycle-level reference model of
// the arbiter; expected responses queue up at acceptance and a separate
// monitor retires them as the DUT presents them.
// ---------------------------------------------------------------------------
module tb_nand_share_arb;

  localparam int N   = 4;
  localparam int W   = 16;
  localparam int IDW = 2;

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   tb_valid;
  logic [N*W-1:0] tb_a;
  logic [N*W-1:0] tb_b;
  logic           tb_rsp_ready;

  nand_share_arb_if #(.N(N), .WIDTH(W), .IDW(IDW)) bus ();

  assign bus.req_valid = tb_valid;
  assign bus.req_a     = tb_a;
  assign bus.req_b     = tb_b;
  assign bus.rsp_ready = tb_rsp_ready;

  nand_share_arb #(.N(N), .WIDTH(W), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   tests  = 0;
  int   errors = 0;
  int   cyc    = 0;
  rsp_t exp_q[$];
  int   glog_id[$];
  int   glog_cyc[$];
  logic [N-1:0] acc = '0;
  bit   reissue = 1'b0;

  // reference model state
  bit m_busy  = 1'b0;
  int m_cnt   = 0;
  int m_last  = N - 1;
  bit rst_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Plain round-robin: first valid requester after the last winner, wrapping.
  function automatic int model_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // Reference model and grant checking, sampled mid-cycle.
  initial begin
    int w;
    logic [N-1:0] exp_rdy;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        if (rst_prev) check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        exp_q.delete();
        m_busy = 1'b0;
        m_cnt  = 0;
        m_last = N - 1;
        acc    = '0;
      end else if (m_busy) begin
        check("busy_req_ready", 32'(bus.req_ready), 32'd0);
        check("rsp_valid_timing", 32'(bus.rsp_valid), 32'(m_cnt >= 2));
        if (m_cnt >= 2 && tb_rsp_ready) m_busy = 1'b0;
        m_cnt++;
      end else begin
        w = model_pick(tb_valid, m_last);
        exp_rdy = '0;
        if (w >= 0) exp_rdy[w] = 1'b1;
        check("grant", 32'(bus.req_ready), 32'(exp_rdy));
        check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        for (int i = 0; i < N; i++) begin
          if (bus.req_ready[i]) begin
            glog_id.push_back(i);
            glog_cyc.push_back(cyc);
          end
        end
        if (w >= 0) begin
          exp_q.push_back('{id: IDW'(w), data: ~(tb_a[w*W +: W] & tb_b[w*W +: W])});
          m_busy = 1'b1;
          m_cnt  = 1;
          m_last = w;
          acc[w] = 1'b1;
        end
      end
      rst_prev = rst;
    end
  end

  // Response monitor: compares each presented response with the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && bus.rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          tests++;
          errors++;
          $display("FAIL unexpected_rsp: got id %0d data %h expected no response", bus.rsp_id, bus.rsp_data);
        end else begin
          check("rsp_id", 32'(bus.rsp_id), 32'(exp_q[0].id));
          check("rsp_data", 32'(bus.rsp_data), 32'(exp_q[0].data));
          if (tb_rsp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    tb_valid[i]      = 1'b1;
    tb_a[i*W +: W]   = a;
    tb_b[i*W +: W]   = b;
  endtask

  // Advance one cycle; retire requests the model saw accepted.
  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        acc[i] = 1'b0;
        if (reissue) set_req(i, 16'($urandom), 16'($urandom));
        else tb_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      if (!m_busy && exp_q.size() == 0 && tb_valid == '0) ok = 1'b1;
      else tick();
    end
    check("idle_timeout", 32'(ok), 32'd1);
  endtask

  // One isolated request; checks latency and the known result value.
  task automatic do_single(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] expd);
    int n0;
    bit got;
    n0 = glog_id.size();
    set_req(id, a, b);
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (glog_id.size() > n0) got = 1'b1;
    end
    check("single_grant_seen", 32'(got), 32'd1);
    if (got) begin
      check("single_grant_id", 32'(glog_id[n0]), 32'(id));
      check("single_lat_n1", 32'(bus.rsp_valid), 32'd0);
      tick();
      check("single_lat_n2", 32'(bus.rsp_valid), 32'd1);
      check("single_id", 32'(bus.rsp_id), 32'(id));
      check("single_data", 32'(bus.rsp_data), 32'(expd));
    end
    wait_idle();
  endtask

  initial begin
    logic [IDW-1:0] cap_id;
    logic [W-1:0]   cap_data;
    bit             seen;
    logic [W-1:0]   ex_a [3];
    logic [W-1:0]   ex_b [3];
    logic [W-1:0]   ex_y [3];
    int             fair_ids [5];

    ex_a = '{16'h0000, 16'hFFFF, 16'hFFFF};
    ex_b = '{16'h0000, 16'h0000, 16'hFFFF};
    ex_y = '{16'hFFFF, 16'hFFFF, 16'h0000};
    fair_ids = '{0, 1, 2, 3, 0};

    // Reset with every requester asserting.
    rst = 1'b1;
    tb_rsp_ready = 1'b1;
    tb_valid = '0;
    for (int i = 0; i < N; i++) set_req(i, 16'($urandom), 16'($urandom));
    tick();
    tick();
    glog_id.delete();
    glog_cyc.delete();
    rst = 1'b0;

    // Fairness with all requesters held valid continuously.
    reissue = 1'b1;
    for (int k = 0; k < 40 && glog_id.size() < 5; k++) tick();
    check("fair_count", 32'(glog_id.size() >= 5), 32'd1);
    if (glog_id.size() >= 5) begin
      check("fair_first_cycle", 32'(glog_cyc[0] == 2), 32'd1);
      for (int k = 0; k < 5; k++) check("fair_order", 32'(glog_id[k]), 32'(fair_ids[k]));
      for (int k = 1; k < 5; k++) check("fair_spacing", 32'(glog_cyc[k] - glog_cyc[k-1]), 32'd3);
    end
    reissue = 1'b0;
    tb_valid = '0;
    wait_idle();

    // Single request on requester 2.
    do_single(2, 16'hFFFF, 16'h00FF, 16'hFF00);

    // Response stall for 5 cycles with another requester waiting.
    tb_rsp_ready = 1'b0;
    set_req(1, 16'($urandom), 16'($urandom));
    set_req(3, 16'($urandom), 16'($urandom));
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (bus.rsp_valid === 1'b1) seen = 1'b1;
    end
    check("stall_rsp_seen", 32'(seen), 32'd1);
    cap_id = bus.rsp_id;
    cap_data = bus.rsp_data;
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", 32'(bus.rsp_valid), 32'd1);
      check("stall_id", 32'(bus.rsp_id), 32'(cap_id));
      check("stall_data", 32'(bus.rsp_data), 32'(cap_data));
      check("stall_ready", 32'(bus.req_ready), 32'd0);
      tick();
    end
    tb_rsp_ready = 1'b1;
    wait_idle();

    // Reset while the operation is in EXEC.
    set_req(2, 16'h1234, 16'h5678);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      tick();
      if (glog_id.size() > 0 && glog_cyc[glog_id.size()-1] == cyc) seen = 1'b1;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    glog_id.delete();
    glog_cyc.delete();
    set_req(1, 16'($urandom), 16'($urandom));
    set_req(0, 16'($urandom), 16'($urandom));
    tick();
    check("post_rst_grant", 32'(glog_id.size() > 0 ? glog_id[0] : -1), 32'd0);
    wait_idle();

    // Single-gate truth table corners.
    for (int k = 0; k < 3; k++) do_single(int'($urandom_range(0, N-1)), ex_a[k], ex_b[k], ex_y[k]);

    // Random traffic with random back-pressure and occasional withdrawal.
    for (int c = 0; c < 600; c++) begin
      tick();
      tb_rsp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!tb_valid[i]) begin
          if ($urandom_range(0, 2) == 0) set_req(i, 16'($urandom), 16'($urandom));
        end else if ($urandom_range(0, 15) == 0) begin
          tb_valid[i] = 1'b0;
        end
      end
    end
    tb_valid = '0;
    tb_rsp_ready = 1'b1;
    wait_idle();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
